l1_ahb_mtx_out_stage: RTL and testbench

Output stage of the L1 AHB bus matrix: the slave-facing end of the matrix, one instance per output port (MI). It collects select requests from every input-stage decoder routed to this port and arbitrates between them round-robin. Burst and locked sequences are never split. It drives the winning input's address/control onto the slave AHB interface, steers write data in the data phase, and returns per-input `active` flags to the decoders.

---
 rtl/l1_ahb_mtx_pkg.sv | 32 +++
 rtl/l1_ahb_mtx_rr_arb.sv | 26 ++
 rtl/l1_ahb_mtx_out_stage.sv | 140 ++++++++++++++
 tb/tb_l1_ahb_mtx_out_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_ahb_mtx_pkg.sv
// Shared AHB encodings and helpers for the L1 bus matrix.
package l1_ahb_mtx_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    // Beats still to come after the NONSEQ of a fixed-length burst; 0 otherwise.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
            HBURST_WRAP16, HBURST_INCR16: return 4'd15;
            default:                      return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/l1_ahb_mtx_rr_arb.sv
// Combinational round-robin pick: first requester above 'last', wrapping.
module l1_ahb_mtx_rr_arb
    import l1_ahb_mtx_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic [IDX_W-1:0]  winner,
    output logic              any
);

    // Scan from last+1 upward modulo NUM_IN; the first hit wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = 1; k <= NUM_IN; k++) begin
            if (!any && req[(int'(last) + k) % NUM_IN]) begin
                any    = 1'b1;
                winner = IDX_W'((int'(last) + k) % NUM_IN);
            end
        end
    end

endmodule

// File: rtl/l1_ahb_mtx_out_stage.sv
// Slave-facing output stage of the L1 AHB matrix: round-robin arbitration
// that never splits bursts or locked sequences, address/control mux and
// data-phase write-data steering.
module l1_ahb_mtx_out_stage
    import l1_ahb_mtx_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       HREADYM,
    input  logic [NUM_IN-1:0]          sel_op,
    input  logic [NUM_IN*ADDR_W-1:0]   addr_op,
    input  logic [NUM_IN*2-1:0]        trans_op,
    input  logic [NUM_IN-1:0]          write_op,
    input  logic [NUM_IN*3-1:0]        size_op,
    input  logic [NUM_IN*3-1:0]        burst_op,
    input  logic [NUM_IN*4-1:0]        prot_op,
    input  logic [NUM_IN-1:0]          mastlock_op,
    input  logic [NUM_IN*DATA_W-1:0]   wdata_op,
    output logic [NUM_IN-1:0]          active_op,
    output logic                       HSELM,
    output logic [ADDR_W-1:0]          HADDRM,
    output logic [1:0]                 HTRANSM,
    output logic                       HWRITEM,
    output logic [2:0]                 HSIZEM,
    output logic [2:0]                 HBURSTM,
    output logic [3:0]                 HPROTM,
    output logic                       HMASTLOCKM,
    output logic [DATA_W-1:0]          HWDATAM
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  last;
    logic              no_port;
    logic [3:0]        beat_cnt;
    logic [IDX_W-1:0]  data_port;

    logic [NUM_IN-1:0] req;
    logic [IDX_W-1:0]  winner;
    logic              any;
    logic              hold;
    logic [3:0]        beat_nxt;

    // Requests: selected and not idle.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            req[i] = sel_op[i] && (trans_op[2*i +: 2] != HTRANS_IDLE);
        end
    end

    l1_ahb_mtx_rr_arb #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req    (req),
        .last   (last),
        .winner (winner),
        .any    (any)
    );

    // Address-phase mux; a parked port keeps its controls but shows no transfer.
    always_comb begin
        HSELM      = ~no_port & sel_op[grant];
        HTRANSM    = HSELM ? trans_op[int'(grant)*2 +: 2] : HTRANS_IDLE;
        HMASTLOCKM = ~no_port & mastlock_op[grant];
        HADDRM     = addr_op[int'(grant)*ADDR_W +: ADDR_W];
        HWRITEM    = write_op[grant];
        HSIZEM     = size_op[int'(grant)*3 +: 3];
        HBURSTM    = burst_op[int'(grant)*3 +: 3];
        HPROTM     = prot_op[int'(grant)*4 +: 4];
        HWDATAM    = wdata_op[int'(data_port)*DATA_W +: DATA_W];
        active_op  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            active_op[i] = ~no_port & (grant == IDX_W'(i)) & sel_op[i];
        end
    end

    // Burst/lock tracking from the beat currently on the slave bus.
    always_comb begin
        hold     = 1'b0;
        beat_nxt = beat_cnt;
        case (HTRANSM)
            HTRANS_IDLE: hold = 1'b0;
            HTRANS_BUSY: hold = 1'b1;
            HTRANS_NONSEQ: begin
                if (HBURSTM == HBURST_SINGLE) begin
                    hold = 1'b0;
                end else if (HBURSTM == HBURST_INCR) begin
                    hold     = 1'b1;
                    beat_nxt = 4'd0;
                end else begin
                    hold     = 1'b1;
                    beat_nxt = burst_beats(HBURSTM);
                end
            end
            HTRANS_SEQ: begin
                if (HBURSTM == HBURST_INCR) begin
                    hold = 1'b1;
                end else begin
                    beat_nxt = beat_cnt - 4'd1;
                    hold     = (beat_nxt != 4'd0);
                end
            end
            default: hold = 1'b0;
        endcase
        if (HMASTLOCKM) begin
            hold = 1'b1;
        end
    end

    // Arbitration and data-phase owner, advancing only on accepted beats.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant     <= '0;
            last      <= IDX_W'(NUM_IN - 1);
            no_port   <= 1'b1;
            beat_cnt  <= 4'd0;
            data_port <= '0;
        end else if (HREADYM) begin
            beat_cnt  <= beat_nxt;
            data_port <= grant;
            if (!hold) begin
                if (any) begin
                    grant   <= winner;
                    last    <= winner;
                    no_port <= 1'b0;
                end else begin
                    no_port <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_l1_ahb_mtx_out_stage.sv
// Directed bench for the matrix output stage with a transaction-level
// ownership model checked against the DUT every cycle.
module tb_l1_ahb_mtx_out_stage;
    import l1_ahb_mtx_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic              HREADYM;
    logic [N-1:0]      sel_op;
    logic [N*AW-1:0]   addr_op;
    logic [N*2-1:0]    trans_op;
    logic [N-1:0]      write_op;
    logic [N*3-1:0]    size_op;
    logic [N*3-1:0]    burst_op;
    logic [N*4-1:0]    prot_op;
    logic [N-1:0]      mastlock_op;
    logic [N*DW-1:0]   wdata_op;
    logic [N-1:0]      active_op;
    logic              HSELM;
    logic [AW-1:0]     HADDRM;
    logic [1:0]        HTRANSM;
    logic              HWRITEM;
    logic [2:0]        HSIZEM;
    logic [2:0]        HBURSTM;
    logic [3:0]        HPROTM;
    logic              HMASTLOCKM;
    logic [DW-1:0]     HWDATAM;

    int checks = 0;
    int errors = 0;

    l1_ahb_mtx_out_stage #(.NUM_IN(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HREADYM     (HREADYM),
        .sel_op      (sel_op),
        .addr_op     (addr_op),
        .trans_op    (trans_op),
        .write_op    (write_op),
        .size_op     (size_op),
        .burst_op    (burst_op),
        .prot_op     (prot_op),
        .mastlock_op (mastlock_op),
        .wdata_op    (wdata_op),
        .active_op   (active_op),
        .HSELM       (HSELM),
        .HADDRM      (HADDRM),
        .HTRANSM     (HTRANSM),
        .HWRITEM     (HWRITEM),
        .HSIZEM      (HSIZEM),
        .HBURSTM     (HBURSTM),
        .HPROTM      (HPROTM),
        .HMASTLOCKM  (HMASTLOCKM),
        .HWDATAM     (HWDATAM)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- ownership model ----------------
    // Who owns the slave bus, whose turn is next, and how many beats of a
    // fixed burst remain (-1 for an open-ended INCR).
    int m_owner = 0;
    int m_last  = N - 1;
    bit m_park  = 1'b1;
    int m_left  = 0;
    int m_data  = 0;

    function automatic logic m_sel();
        return !m_park && sel_op[m_owner];
    endfunction

    function automatic logic [1:0] m_trans();
        return m_sel() ? trans_op[2*m_owner +: 2] : 2'b00;
    endfunction

    function automatic logic m_lock();
        return !m_park && mastlock_op[m_owner];
    endfunction

    function automatic int burst_len(input logic [2:0] b);
        if (b == 3'd2 || b == 3'd3) return 4;
        if (b == 3'd4 || b == 3'd5) return 8;
        if (b == 3'd6 || b == 3'd7) return 16;
        return 1;
    endfunction

    initial begin : model
        logic [1:0] t;
        logic [2:0] b;
        bit keep;
        bit found;
        int c;
        forever begin
            @(posedge HCLK or negedge HRESETn);
            if (!HRESETn) begin
                m_owner = 0; m_last = N - 1; m_park = 1'b1; m_left = 0; m_data = 0;
            end else if (HREADYM) begin
                t = m_trans();
                b = burst_op[3*m_owner +: 3];
                if (t == 2'b10) begin
                    if (b == 3'd1) m_left = -1;
                    else           m_left = burst_len(b) - 1;
                end else if (t == 2'b11 && m_left > 0) begin
                    m_left = m_left - 1;
                end
                keep = m_lock() || (t == 2'b01) ||
                       ((t == 2'b10 || t == 2'b11) && m_left != 0);
                m_data = m_owner;
                if (!keep) begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_last + k) % N;
                        if (!found && sel_op[c] && trans_op[2*c +: 2] != 2'b00) begin
                            found = 1'b1;
                            m_owner = c;
                            m_last = c;
                        end
                    end
                    m_park = !found;
                end
            end
        end
    end

    // Every cycle out of reset, the bus must show what the model says.
    initial begin : compare
        forever begin
            @(negedge HCLK);
            if (HRESETn) begin
                chk("hsel",   HSELM,      m_sel());
                chk("htrans", HTRANSM,    m_trans());
                chk("hlock",  HMASTLOCKM, m_lock());
                chk("active", active_op,  m_sel() ? (64'd1 << m_owner) : 64'd0);
                chk("haddr",  HADDRM,     addr_op[AW*m_owner +: AW]);
                chk("hburst", HBURSTM,    burst_op[3*m_owner +: 3]);
                chk("hwrite", HWRITEM,    write_op[m_owner]);
                chk("hsize",  HSIZEM,     size_op[3*m_owner +: 3]);
                chk("hprot",  HPROTM,     prot_op[4*m_owner +: 4]);
                chk("hwdata", HWDATAM,    wdata_op[DW*m_data +: DW]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drv(input int i, input bit s, input logic [1:0] t,
                       input logic [2:0] b, input logic [31:0] a, input bit lk);
        sel_op[i]          = s;
        trans_op[2*i +: 2] = t;
        burst_op[3*i +: 3] = b;
        addr_op[AW*i +: AW] = a;
        mastlock_op[i]     = lk;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) drv(i, 1'b0, 2'b00, 3'd0, 32'h0, 1'b0);
    endtask

    task automatic rst_pulse();
        #1 HRESETn = 1'b0;
        #1 HRESETn = 1'b1;
    endtask

    logic [1:0]  t4 [6] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11};
    logic [1:0]  tl [4] = '{2'b10, 2'b10, 2'b00, 2'b00};
    bit          ll [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  rr [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    initial begin : main
        logic [31:0] a;
        HRESETn  = 1'b0;
        HREADYM  = 1'b1;
        sel_op = '0; trans_op = '0; burst_op = '0; addr_op = '0; mastlock_op = '0;
        write_op = 3'b101;
        size_op  = {3'd2, 3'd1, 3'd0};
        prot_op  = {4'h3, 4'h2, 4'h1};
        wdata_op = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // reset then idle
        #1;
        chk("rst_hsel",   HSELM,      1'b0);
        chk("rst_htrans", HTRANSM,    2'b00);
        chk("rst_active", active_op,  3'b000);
        chk("rst_hlock",  HMASTLOCKM, 1'b0);
        cyc();

        // single request from input 1
        drv(1, 1'b1, 2'b10, 3'd0, 32'h1000_0000, 1'b0);
        cyc();
        chk("t1_haddr",  HADDRM,    32'h1000_0000);
        chk("t1_active", active_op, 3'b010);
        chk("t1_hsel",   HSELM,     1'b1);
        idle_all();
        cyc();
        chk("t1_hwdata", HWDATAM,   32'hD000_0001);
        chk("t1_park",   HSELM,     1'b0);

        // strict rotation with three SINGLE requesters
        rst_pulse();
        for (int i = 0; i < N; i++) drv(i, 1'b1, 2'b10, 3'd0, 32'h2000_0000 + i, 1'b0);
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("rr_active", active_op, rr[j]);
        end

        // INCR4 with two BUSY beats against a waiting input 2
        idle_all();
        rst_pulse();
        a = 32'h2000_0000;
        drv(0, 1'b1, 2'b10, 3'd3, a, 1'b0);
        drv(2, 1'b1, 2'b10, 3'd0, 32'h3000_0000, 1'b0);
        cyc();
        for (int k = 0; k < 6; k++) begin
            drv(0, 1'b1, t4[k], 3'd3, a, 1'b0);
            #1 chk("incr4_owner", active_op, 3'b001);
            cyc();
            if (t4[k] != 2'b01) a = a + 4;
        end
        drv(0, 1'b0, 2'b00, 3'd0, 32'h0, 1'b0);
        #1 chk("incr4_next", active_op, 3'b100);
        cyc();

        // INCR8 with a three-cycle stall on the fourth beat
        idle_all();
        rst_pulse();
        drv(0, 1'b1, 2'b10, 3'd5, 32'h4000_0000, 1'b0);
        drv(1, 1'b1, 2'b10, 3'd0, 32'h5000_0000, 1'b0);
        cyc();
        for (int k = 0; k < 8; k++) begin
            drv(0, 1'b1, (k == 0) ? 2'b10 : 2'b11, 3'd5, 32'h4000_0000 + 4*k, 1'b0);
            #1 chk("incr8_owner", active_op, 3'b001);
            if (k == 3) begin
                HREADYM = 1'b0;
                repeat (3) begin
                    cyc();
                    chk("stall_haddr",  HADDRM,       32'h4000_000C);
                    chk("stall_htrans", HTRANSM,      2'b11);
                    chk("stall_active", active_op,    3'b001);
                    chk("stall_beats",  dut.beat_cnt, 4'd5);
                end
                HREADYM = 1'b1;
            end
            cyc();
        end
        drv(0, 1'b0, 2'b00, 3'd0, 32'h0, 1'b0);
        #1 chk("incr8_next", active_op, 3'b010);
        cyc();

        // locked sequence from input 1 against input 0
        idle_all();
        rst_pulse();
        drv(1, 1'b1, 2'b10, 3'd0, 32'h6000_0000, 1'b1);
        cyc();
        drv(0, 1'b1, 2'b10, 3'd0, 32'h7000_0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drv(1, 1'b1, tl[k], 3'd0, 32'h6000_0000 + 4*k, ll[k]);
            #1 chk("lock_owner", active_op, 3'b010);
            chk("lock_hlock", HMASTLOCKM, ll[k]);
            cyc();
        end
        drv(1, 1'b0, 2'b00, 3'd0, 32'h0, 1'b0);
        #1 chk("lock_next", active_op, 3'b001);

        // asynchronous reset during beat 2 of an INCR16
        drv(0, 1'b1, 2'b10, 3'd7, 32'h8000_0000, 1'b0);
        cyc();
        drv(0, 1'b1, 2'b11, 3'd7, 32'h8000_0004, 1'b0);
        #1 chk("i16_owner", active_op, 3'b001);
        #1 HRESETn = 1'b0;
        #1;
        chk("i16_rst_hsel",   HSELM,        1'b0);
        chk("i16_rst_htrans", HTRANSM,      2'b00);
        chk("i16_rst_hlock",  HMASTLOCKM,   1'b0);
        chk("i16_rst_active", active_op,    3'b000);
        chk("i16_rst_beats",  dut.beat_cnt, 4'd0);
        HRESETn = 1'b1;
        drv(0, 1'b1, 2'b10, 3'd0, 32'h9000_0000, 1'b0);
        drv(1, 1'b1, 2'b10, 3'd0, 32'hA000_0000, 1'b0);
        cyc();
        chk("i16_prio0", active_op, 3'b001);
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
